// File: rtl/button_cmd_pkg.sv
// Shared types and code-field helpers for the button command decoder.
// The helpers take the bus width as an argument so one definition serves every N_BUTTONS.
package button_cmd_pkg;

   typedef enum logic {RELEASED = 1'b0, PRESSED = 1'b1} dec_state_t;

   localparam int FREQ_RESET_DEF = 4;
   localparam int LP_RESET_DEF   = 1;
   localparam int HP_RESET_DEF   = 2;

   function automatic logic [31:0] low_mask(input int n);
      return (32'd1 << n) - 32'd1;
   endfunction

   // All low bits set with the top bit clear is the mute code (7 for a 4-bit bus).
   function automatic logic is_mute(input int w, input logic [31:0] code);
      return (code[w-1] == 1'b0) && ((code & low_mask(w-1)) == low_mask(w-1));
   endfunction

   function automatic logic is_freq(input int w, input logic [31:0] code);
      return (code[w-1] == 1'b0) && !is_mute(w, code) && (code != 32'd0);
   endfunction

   function automatic logic is_lp(input int w, input logic [31:0] code);
      return ((code >> (w-2)) & 32'd3) == 32'd2;
   endfunction

   function automatic logic is_hp(input int w, input logic [31:0] code);
      return ((code >> (w-2)) & 32'd3) == 32'd3;
   endfunction

endpackage

// File: rtl/button_cmd_decoder_if.sv
// Button bus in, decoded settings and command strobe out.
interface button_cmd_decoder_if #(parameter int W = 4);
   logic [W-1:0] buttons;
   logic         mute;
   logic [W-2:0] freq_select;
   logic [W-3:0] lowpass_select;
   logic [W-3:0] highpass_select;
   logic         cmd_valid;
   logic [W-1:0] cmd_code;

   modport master (
      output buttons,
      input  mute, freq_select, lowpass_select, highpass_select, cmd_valid, cmd_code
   );

   modport slave (
      input  buttons,
      output mute, freq_select, lowpass_select, highpass_select, cmd_valid, cmd_code
   );
endinterface

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus stability counter; chg pulses for one cycle when a new
// code has been stable long enough to replace stable_code.
module button_debounce #(
   parameter int W               = 4,
   parameter int DEBOUNCE_CYCLES = 48000
) (
   input  logic         clk_48,
   input  logic         reset,
   input  logic [W-1:0] buttons,
   output logic [W-1:0] stable_code,
   output logic         chg
);
   localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [W-1:0]  sync1_q, sync2_q, cand_q, stable_q;
   logic [CW-1:0] cnt_q;
   logic          chg_q;

   always_ff @(posedge clk_48 or posedge reset) begin
      if (reset) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         cand_q   <= '0;
         stable_q <= '0;
         cnt_q    <= '0;
         chg_q    <= 1'b0;
      end else begin
         sync1_q <= buttons;
         sync2_q <= sync1_q;
         chg_q   <= 1'b0;
         if (sync2_q != cand_q) begin
            cand_q <= sync2_q;
            cnt_q  <= '0;
         end else if (cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + 1'b1;
         end else begin
            // Counter parks at terminal count; only a real change of code pulses chg.
            stable_q <= cand_q;
            chg_q    <= (cand_q != stable_q);
         end
      end
   end

   assign stable_code = stable_q;
   assign chg         = chg_q;
endmodule

// File: rtl/button_cmd_decoder.sv
// Debounced button code -> one command per press, applied to persistent strip settings.
//  state    | meaning
//  RELEASED | no code held; next non-zero stable code is a press
//  PRESSED  | a code is held; only a different non-zero code (rollover) issues a command
module button_cmd_decoder
   import button_cmd_pkg::*;
#(
   parameter int N_BUTTONS       = 4,
   parameter int DEBOUNCE_CYCLES = 48000,
   parameter int FREQ_RESET      = FREQ_RESET_DEF,
   parameter int LP_RESET        = LP_RESET_DEF,
   parameter int HP_RESET        = HP_RESET_DEF
) (
   input  logic                 clk_48,
   input  logic                 reset,
   button_cmd_decoder_if.slave  btn
);
   localparam int W = N_BUTTONS;

   logic [W-1:0] stable;
   logic         chg;

   button_debounce #(.W(W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk_48      (clk_48),
      .reset       (reset),
      .buttons     (btn.buttons),
      .stable_code (stable),
      .chg         (chg)
   );

   dec_state_t   state_q, state_d;
   logic         mute_q, mute_d;
   logic [W-2:0] freq_q, freq_d;
   logic [W-3:0] lp_q, lp_d, hp_q, hp_d;
   logic         cmd_valid_q, cmd_valid_d;
   logic [W-1:0] cmd_code_q, cmd_code_d;
   logic         apply;

   always_ff @(posedge clk_48 or posedge reset) begin
      if (reset) begin
         state_q     <= RELEASED;
         mute_q      <= 1'b0;
         freq_q      <= (W-1)'(FREQ_RESET);
         lp_q        <= (W-2)'(LP_RESET);
         hp_q        <= (W-2)'(HP_RESET);
         cmd_valid_q <= 1'b0;
         cmd_code_q  <= '0;
      end else begin
         state_q     <= state_d;
         mute_q      <= mute_d;
         freq_q      <= freq_d;
         lp_q        <= lp_d;
         hp_q        <= hp_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_code_q  <= cmd_code_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      mute_d      = mute_q;
      freq_d      = freq_q;
      lp_d        = lp_q;
      hp_d        = hp_q;
      cmd_valid_d = 1'b0;
      cmd_code_d  = cmd_code_q;
      apply       = 1'b0;

      case (state_q)
         RELEASED: if (chg && (stable != '0)) begin
            apply   = 1'b1;
            state_d = PRESSED;
         end
         PRESSED: if (chg) begin
            if (stable == '0) state_d = RELEASED;
            else              apply   = 1'b1;
         end
         default: state_d = RELEASED;
      endcase

      if (apply) begin
         cmd_valid_d = 1'b1;
         cmd_code_d  = stable;
         if (is_mute(W, 32'(stable)))      mute_d = ~mute_q;
         else if (is_freq(W, 32'(stable))) freq_d = stable[W-2:0];
         else if (is_lp(W, 32'(stable)))   lp_d   = stable[W-3:0];
         else if (is_hp(W, 32'(stable)))   hp_d   = stable[W-3:0];
      end
   end

   assign btn.mute            = mute_q;
   assign btn.freq_select     = freq_q;
   assign btn.lowpass_select  = lp_q;
   assign btn.highpass_select = hp_q;
   assign btn.cmd_valid       = cmd_valid_q;
   assign btn.cmd_code        = cmd_code_q;
endmodule

// File: tb/tb_button_cmd_decoder.sv
// Directed bench for button_cmd_decoder with a 4-bit bus and an 8-cycle debounce.
module tb_button_cmd_decoder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   pulses = 0;

   always #5 clk = ~clk;

   button_cmd_decoder_if #(.W(4)) bus ();

   button_cmd_decoder #(
      .N_BUTTONS(4), .DEBOUNCE_CYCLES(8),
      .FREQ_RESET(4), .LP_RESET(1), .HP_RESET(2)
   ) dut (
      .clk_48 (clk),
      .reset  (rst),
      .btn    (bus)
   );

   // Drive a code and run for cyc cycles, counting cmd_valid samples.
   task automatic hold(input logic [3:0] code, input int cyc);
      @(negedge clk);
      bus.buttons = code;
      repeat (cyc) begin
         @(posedge clk);
         #1;
         if (bus.cmd_valid === 1'b1) pulses++;
      end
   endtask

   task automatic test_reset;
      bus.buttons = 4'd0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.mute !== 1'b0)            begin errors++; $display("FAIL reset_mute got %0d want 0", bus.mute); end
      checks++; if (bus.freq_select !== 3'd4)     begin errors++; $display("FAIL reset_freq got %0d want 4", bus.freq_select); end
      checks++; if (bus.lowpass_select !== 2'd1)  begin errors++; $display("FAIL reset_lp got %0d want 1", bus.lowpass_select); end
      checks++; if (bus.highpass_select !== 2'd2) begin errors++; $display("FAIL reset_hp got %0d want 2", bus.highpass_select); end
      checks++; if (bus.cmd_valid !== 1'b0)       begin errors++; $display("FAIL reset_valid got %0d want 0", bus.cmd_valid); end
      checks++; if (bus.cmd_code !== 4'd0)        begin errors++; $display("FAIL reset_code got %0d want 0", bus.cmd_code); end
      @(negedge clk);
      rst = 1'b0;
      hold(4'd0, 4);
   endtask

   task automatic test_lp_latency;
      pulses = 0;
      @(negedge clk);
      bus.buttons = 4'd10;
      @(posedge clk);
      repeat (10) @(posedge clk);
      #1;
      checks++; if (bus.lowpass_select !== 2'd1 || bus.cmd_valid !== 1'b0) begin
         errors++; $display("FAIL lp_early lp=%0d valid=%0d want lp=1 valid=0", bus.lowpass_select, bus.cmd_valid);
      end
      @(posedge clk);
      #1;
      checks++; if (bus.lowpass_select !== 2'd2) begin errors++; $display("FAIL lp_at_11 got %0d want 2", bus.lowpass_select); end
      checks++; if (bus.cmd_valid !== 1'b1)      begin errors++; $display("FAIL lp_valid got %0d want 1", bus.cmd_valid); end
      checks++; if (bus.cmd_code !== 4'd10)      begin errors++; $display("FAIL lp_code got %0d want 10", bus.cmd_code); end
      pulses = 1;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (bus.cmd_valid === 1'b1) pulses++;
      end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL lp_pulses got %0d want 1", pulses); end
      pulses = 0;
      hold(4'd0, 20);
      checks++; if (pulses !== 0) begin errors++; $display("FAIL lp_release_pulses got %0d want 0", pulses); end
      checks++; if (bus.cmd_code !== 4'd10) begin errors++; $display("FAIL lp_code_held got %0d want 10", bus.cmd_code); end
   endtask

   task automatic test_mute_toggle;
      pulses = 0;
      hold(4'd7, 100);
      checks++; if (bus.mute !== 1'b1) begin errors++; $display("FAIL mute_on got %0d want 1", bus.mute); end
      checks++; if (pulses !== 1)      begin errors++; $display("FAIL mute_hold_pulses got %0d want 1", pulses); end
      hold(4'd0, 20);
      hold(4'd7, 20);
      checks++; if (bus.mute !== 1'b0) begin errors++; $display("FAIL mute_off got %0d want 0", bus.mute); end
      hold(4'd0, 20);
      checks++; if (pulses !== 2)      begin errors++; $display("FAIL mute_pulses got %0d want 2", pulses); end
   endtask

   task automatic test_glitch;
      pulses = 0;
      hold(4'd13, 5);
      hold(4'd0, 20);
      checks++; if (pulses !== 0)                 begin errors++; $display("FAIL glitch_pulses got %0d want 0", pulses); end
      checks++; if (bus.highpass_select !== 2'd2) begin errors++; $display("FAIL glitch_hp got %0d want 2", bus.highpass_select); end
   endtask

   task automatic test_back_to_back;
      pulses = 0;
      hold(4'd9, 20);
      checks++; if (bus.lowpass_select !== 2'd1 || bus.cmd_code !== 4'd9) begin
         errors++; $display("FAIL roll_lp lp=%0d code=%0d want lp=1 code=9", bus.lowpass_select, bus.cmd_code);
      end
      hold(4'd13, 20);
      checks++; if (bus.highpass_select !== 2'd1 || bus.cmd_code !== 4'd13) begin
         errors++; $display("FAIL roll_hp hp=%0d code=%0d want hp=1 code=13", bus.highpass_select, bus.cmd_code);
      end
      checks++; if (pulses !== 2) begin errors++; $display("FAIL roll_pulses got %0d want 2", pulses); end
      pulses = 0;
      hold(4'd0, 20);
      checks++; if (pulses !== 0) begin errors++; $display("FAIL roll_release_pulses got %0d want 0", pulses); end
   endtask

   task automatic test_reset_mid;
      pulses = 0;
      hold(4'd3, 20);
      hold(4'd0, 20);
      hold(4'd7, 20);
      checks++; if (bus.freq_select !== 3'd3 || bus.mute !== 1'b1) begin
         errors++; $display("FAIL pre_reset freq=%0d mute=%0d want freq=3 mute=1", bus.freq_select, bus.mute);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (bus.mute !== 1'b0 || bus.freq_select !== 3'd4 || bus.lowpass_select !== 2'd1 ||
                    bus.highpass_select !== 2'd2 || bus.cmd_valid !== 1'b0) begin
         errors++; $display("FAIL async_reset mute=%0d freq=%0d lp=%0d hp=%0d valid=%0d want 0 4 1 2 0",
                            bus.mute, bus.freq_select, bus.lowpass_select, bus.highpass_select, bus.cmd_valid);
      end
      bus.buttons = 4'd0;
      @(negedge clk);
      rst = 1'b0;
      hold(4'd0, 5);
   endtask

   task automatic test_reset_settling;
      @(negedge clk);
      bus.buttons = 4'd5;
      @(posedge clk);
      repeat (6) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++; if (bus.freq_select !== 3'd4 || bus.cmd_valid !== 1'b0) begin
         errors++; $display("FAIL settle_reset freq=%0d valid=%0d want 4 0", bus.freq_select, bus.cmd_valid);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      hold(4'd5, 30);
      checks++; if (bus.freq_select !== 3'd5) begin errors++; $display("FAIL settle_freq got %0d want 5", bus.freq_select); end
      checks++; if (pulses !== 1)             begin errors++; $display("FAIL settle_pulses got %0d want 1", pulses); end
      pulses = 0;
      hold(4'd0, 20);
      checks++; if (pulses !== 0)             begin errors++; $display("FAIL settle_release_pulses got %0d want 0", pulses); end
   endtask

   initial begin
      test_reset;
      test_lp_latency;
      test_mute_toggle;
      test_glitch;
      test_back_to_back;
      test_reset_mid;
      test_reset_settling;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
